pcie_ss_axis_wrr_sched: RTL and testbench
=========================================

Name: pcie_ss_axis_wrr_sched

Overview:
- Packet-level weighted round-robin scheduler that decides which of NUM_CH PCIe SS AXI-S requesters owns a shared output datapath.
- Sits beside an AXI-S mux datapath: consumes head-of-queue valids and the accepted-beat/tlast strobe of the granted stream, and drives a registered grant that the mux uses as its select and tready steering.
- Grants whole packets only. A channel with weight W gets up to W consecutive packets before the pointer moves on.
- Includes a per-packet stall watchdog.

Parameters:
- NUM_CH, 4, number of requesters (≥2).
- W_WIDTH, 4, width of each per-channel weight field.
- TIMEOUT_W, 16, width of the stall watchdog counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_enable  in  NUM_CH  per-channel enable; a disabled channel is never newly granted.
- cfg_weight  in  NUM_CH*W_WIDTH  per-channel packet quota; field c is bits [c*W_WIDTH +: W_WIDTH]; value 0 is treated as 1.
- cfg_timeout  in  TIMEOUT_W  stall limit in cycles; 0 disables the watchdog.
- req  in  NUM_CH  head-of-queue tvalid per channel.
- beat_xfer  in  1  granted channel's beat transferred this cycle (tvalid&tready at the mux input).
- beat_last  in  1  tlast of that beat; qualified by beat_xfer.
- grant_valid  out  1  a channel owns the datapath.
- grant_1hot  out  NUM_CH  one-hot owner; all-zero when grant_valid=0.
- grant_idx  out  $clog2(NUM_CH)  binary owner index.
- err_timeout  out  1  sticky stall flag.
- err_chan  out  $clog2(NUM_CH)  channel that was granted when err_timeout set.

Behaviour:
- State machine: ARB → BUSY → ARB. Reset state ARB.
- Reset values: grant_valid=0, grant_1hot=0, grant_idx=0, err_timeout=0, err_chan=0, ptr=0, quota_left=0, stall counter=0.
- All outputs are registered.
- ARB, eligibility: elig = req & cfg_enable.
  - If elig=0: stay in ARB; outputs hold at grant_valid=0.
  - Continue case: if elig[ptr] and quota_left≠0, grant ptr and set quota_left ← quota_left−1.
  - Move case: otherwise pick the first set bit of elig searching ptr+1, ptr+2, … circularly, wrapping NUM_CH−1→0; ptr itself is searched last. Set ptr ← winner, grant winner, quota_left ← eff_weight(winner)−1, where eff_weight = max(weight,1).
  - On any grant: next cycle grant_valid=1, grant_1hot/grant_idx = winner, state → BUSY. Latency from req to grant is 1 cycle.
- BUSY:
  - Grant held constant; req and cfg changes are ignored.
  - beat_xfer&beat_last → next cycle grant_valid=0, grant_1hot=0, state → ARB.
  - This gives exactly one idle arbitration cycle between packets.
  - beat_xfer&!beat_last → stay in BUSY.
  - beat_xfer while in ARB is a protocol violation and is ignored.
- Weights are sampled only at reload (move case). A weight change never affects an in-progress quota.
- cfg_enable deasserted for the granted channel mid-packet: the packet completes normally. At the next ARB the channel is ineligible, so it takes the move path.
- Quota exhaustion: when quota_left=0 in ARB, the current ptr is searched last. If it is the only eligible channel it is re-granted with a fresh quota.
- Watchdog:
  - In BUSY, the counter increments each cycle with no beat_xfer, saturating at all-ones.
  - It clears on beat_xfer and on entering ARB.
  - When cfg_timeout≠0 and count reaches cfg_timeout: err_timeout←1 and err_chan←grant_idx, sticky until reset.
  - The grant is not released; recovery is by reset.
- Reset asserted mid-packet: all state returns to reset values on the same edge. No partial quota is retained.
- grant_1hot always has at most one bit set and is consistent with grant_idx whenever grant_valid=1.

Test Plan:
1. Reset, weights all 1, req=4'b1111 continuously, each packet 1 beat (beat_xfer=beat_last=1 every BUSY cycle) → grant order 1,2,3,0,1,… (ptr starts 0, searched last); grant_valid toggles 1,0,1,0.
2. Weights {ch0=3, ch1=1, others 1}, req=4'b0011, 2-beat packets → grant sequence 1,0,0,0,1,0,0,0…; ch0 gets 3 packets per ch1 packet.
3. ch2 granted with a 5-beat packet; cfg_enable[2] dropped after beat 2 → grant stays ch2 through beat 5, then the next grant goes to a different eligible channel; ch2 is not re-granted while disabled.
4. cfg_timeout=10, ch1 granted, beat_xfer held 0 → err_timeout=1 and err_chan=1 on the 10th stalled cycle; grant_valid stays 1; the flag persists after beats resume.
5. Only ch3 requesting, weight=2, 6 single-beat packets → all grants to ch3; quota reloads after every 2 packets; no gaps beyond the single ARB cycle.
6. rst_n asserted while BUSY mid-packet → next cycle grant_valid=0, err_timeout=0; the first post-reset grant follows the ptr=0 search order (ch1 first when all request).

Source files
------------

// File: rtl/pcie_ss_axis_wrr_sched.sv
// Packet-level weighted round-robin grant scheduler for a shared PCIe SS AXI-S datapath.
// Grants whole packets, holds the owner until tlast, and flags stalled packets with a sticky watchdog.
module pcie_ss_axis_wrr_sched #(
    parameter int NUM_CH    = 4,
    parameter int W_WIDTH   = 4,
    parameter int TIMEOUT_W = 16,
    localparam int IDX_W    = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           cfg_enable,
    input  logic [NUM_CH*W_WIDTH-1:0]   cfg_weight,
    input  logic [TIMEOUT_W-1:0]        cfg_timeout,
    input  logic [NUM_CH-1:0]           req,
    input  logic                        beat_xfer,
    input  logic                        beat_last,
    output logic                        grant_valid,
    output logic [NUM_CH-1:0]           grant_1hot,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        err_timeout,
    output logic [IDX_W-1:0]            err_chan
);

    typedef enum logic {ARB, BUSY} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [W_WIDTH-1:0]   quota_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 grant_valid_q;
    logic [NUM_CH-1:0]    grant_1hot_q;
    logic [IDX_W-1:0]     grant_idx_q;
    logic                 err_q;
    logic [IDX_W-1:0]     err_chan_q;

    logic [NUM_CH-1:0]    elig;
    logic                 found;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     move_idx;
    logic [W_WIDTH-1:0]   move_w;
    logic                 cont_ok;
    logic [IDX_W-1:0]     grant_idx_d;
    logic [W_WIDTH-1:0]   quota_d;
    logic [TIMEOUT_W-1:0] cnt_d;

    // A zero weight behaves as one, so the reload value is max(w,1)-1.
    function automatic logic [W_WIDTH-1:0] eff_reload(input logic [W_WIDTH-1:0] w);
        return (w == '0) ? '0 : w - W_WIDTH'(1);
    endfunction

    function automatic logic [NUM_CH-1:0] to_1hot(input logic [IDX_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        elig     = req & cfg_enable;
        found    = 1'b0;
        cand     = ptr_q;
        move_idx = ptr_q;
        // Circular search starting after ptr; ptr itself is visited last.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_CH);
            if (!found && elig[cand]) begin
                found    = 1'b1;
                move_idx = cand;
            end
        end
        move_w = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (move_idx == IDX_W'(c)) begin
                move_w = cfg_weight[c*W_WIDTH +: W_WIDTH];
            end
        end
        cont_ok     = elig[ptr_q] && (quota_q != '0);
        grant_idx_d = cont_ok ? ptr_q : move_idx;
        quota_d     = cont_ok ? quota_q - W_WIDTH'(1) : eff_reload(move_w);
        cnt_d       = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARB;
            ptr_q         <= '0;
            quota_q       <= '0;
            cnt_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_1hot_q  <= '0;
            grant_idx_q   <= '0;
            err_q         <= 1'b0;
            err_chan_q    <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    cnt_q <= '0;
                    if (elig != '0) begin
                        state_q       <= BUSY;
                        ptr_q         <= grant_idx_d;
                        quota_q       <= quota_d;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= grant_idx_d;
                        grant_1hot_q  <= to_1hot(grant_idx_d);
                    end
                end
                BUSY: begin
                    if (beat_xfer) begin
                        cnt_q <= '0;
                        if (beat_last) begin
                            state_q       <= ARB;
                            grant_valid_q <= 1'b0;
                            grant_1hot_q  <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        // The grant is deliberately kept; only reset recovers a stalled owner.
                        if (!err_q && cfg_timeout != '0 && cnt_d >= cfg_timeout) begin
                            err_q      <= 1'b1;
                            err_chan_q <= grant_idx_q;
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_1hot  = grant_1hot_q;
    assign grant_idx   = grant_idx_q;
    assign err_timeout = err_q;
    assign err_chan    = err_chan_q;

endmodule

// File: tb/tb_pcie_ss_axis_wrr_sched.sv
// Randomized and directed bench for pcie_ss_axis_wrr_sched against a packet-level WRR model.
module tb_pcie_ss_axis_wrr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cfg_enable = '0;
    logic [15:0] cfg_weight = '0;
    logic [15:0] cfg_timeout = '0;
    logic [3:0]  req = '0;
    logic        beat_xfer = 1'b0;
    logic        beat_last = 1'b0;
    logic        grant_valid;
    logic [3:0]  grant_1hot;
    logic [1:0]  grant_idx;
    logic        err_timeout;
    logic [1:0]  err_chan;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    int m_quota = 0;

    pcie_ss_axis_wrr_sched #(.NUM_CH(4), .W_WIDTH(4), .TIMEOUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_weight(cfg_weight),
        .cfg_timeout(cfg_timeout), .req(req), .beat_xfer(beat_xfer), .beat_last(beat_last),
        .grant_valid(grant_valid), .grant_1hot(grant_1hot), .grant_idx(grant_idx),
        .err_timeout(err_timeout), .err_chan(err_chan)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_timeout: time limit reached, bench did not complete");
        $fatal(1, "time limit");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Reference: a channel keeps ownership for max(w,1) consecutive packets while eligible;
    // otherwise the next eligible channel after the pointer (pointer last) wins and reloads.
    function automatic int pick(input logic [3:0] e, input logic [15:0] w);
        int wv;
        if (e == 4'b0) return -1;
        if (e[m_ptr] && m_quota != 0) begin
            m_quota = m_quota - 1;
            return m_ptr;
        end
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (e[c]) begin
                m_ptr = c;
                wv = int'((w >> (4 * c)) & 16'hF);
                m_quota = (wv == 0) ? 0 : wv - 1;
                return c;
            end
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; beat_xfer = 1'b0; beat_last = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        m_ptr = 0; m_quota = 0;
    endtask

    // Drives one arbitration cycle plus a packet of len beats, reporting what the DUT showed.
    task automatic run_pkt(input int len, input int stall_max, input int drop_after, input int drop_ch,
                           output int g_idx, output logic [3:0] g_1hot, output logic g_vld,
                           output logic held_ok, output logic rel_ok);
        int ns;
        beat_xfer = 1'b0; beat_last = 1'b0;
        cyc();
        g_vld = grant_valid; g_idx = int'(grant_idx); g_1hot = grant_1hot; held_ok = 1'b1;
        for (int b = 0; b < len; b++) begin
            ns = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            for (int s = 0; s < ns; s++) begin
                beat_xfer = 1'b0;
                cyc();
                if (grant_valid !== 1'b1 || int'(grant_idx) != g_idx || grant_1hot !== g_1hot) held_ok = 1'b0;
            end
            beat_xfer = 1'b1; beat_last = (b == len - 1);
            cyc();
            beat_xfer = 1'b0; beat_last = 1'b0;
            if (b == drop_after - 1) cfg_enable[drop_ch] = 1'b0;
            if (b < len - 1 && (grant_valid !== 1'b1 || int'(grant_idx) != g_idx || grant_1hot !== g_1hot))
                held_ok = 1'b0;
        end
        rel_ok = (grant_valid === 1'b0 && grant_1hot === 4'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
        total++; if (grant_1hot !== 4'b0) begin bad++; $display("FAIL reset_1hot: got %b want 0000", grant_1hot); end
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        total++; if (err_chan !== 2'd0) begin bad++; $display("FAIL reset_errchan: got %0d want 0", err_chan); end
    endtask

    task automatic test_rr_equal();
        int exp, gi; logic [3:0] g1; logic gv, ho, ro;
        do_reset();
        cfg_weight = 16'h1111; cfg_enable = 4'hF; req = 4'hF; cfg_timeout = '0;
        for (int k = 0; k < 8; k++) begin
            exp = pick(req & cfg_enable, cfg_weight);
            run_pkt(1, 0, 0, 0, gi, g1, gv, ho, ro);
            total++; if (gv !== 1'b1) begin bad++; $display("FAIL rr_gv pkt%0d: got %b want 1", k, gv); end
            total++; if (gi != (k + 1) % 4) begin bad++; $display("FAIL rr_order pkt%0d: got %0d want %0d", k, gi, (k + 1) % 4); end
            total++; if (gi != exp) begin bad++; $display("FAIL rr_model pkt%0d: got %0d want %0d", k, gi, exp); end
            total++; if (g1 !== 4'(1 << exp)) begin bad++; $display("FAIL rr_1hot pkt%0d: got %b want %b", k, g1, 4'(1 << exp)); end
            total++; if (ro !== 1'b1) begin bad++; $display("FAIL rr_release pkt%0d: got gv=%b want 0", k, grant_valid); end
        end
    endtask

    task automatic test_weighted();
        int exp, gi; logic [3:0] g1; logic gv, ho, ro;
        int seq[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        do_reset();
        cfg_weight = 16'h1113; cfg_enable = 4'hF; req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            exp = pick(req & cfg_enable, cfg_weight);
            run_pkt(2, 0, 0, 0, gi, g1, gv, ho, ro);
            total++; if (gi != seq[k] || gv !== 1'b1) begin bad++; $display("FAIL wrr_seq pkt%0d: got %0d gv=%b want %0d", k, gi, gv, seq[k]); end
            total++; if (gi != exp) begin bad++; $display("FAIL wrr_model pkt%0d: got %0d want %0d", k, gi, exp); end
            total++; if (ho !== 1'b1 || ro !== 1'b1) begin bad++; $display("FAIL wrr_hold pkt%0d: got held=%b rel=%b want 1 1", k, ho, ro); end
        end
    endtask

    task automatic test_enable_drop();
        int exp, gi; logic [3:0] g1; logic gv, ho, ro;
        do_reset();
        cfg_weight = 16'h1111; cfg_enable = 4'hF; req = 4'b0100;
        exp = pick(req & cfg_enable, cfg_weight);
        run_pkt(5, 0, 2, 2, gi, g1, gv, ho, ro);
        total++; if (gi != 2 || gv !== 1'b1) begin bad++; $display("FAIL en_first: got %0d want 2", gi); end
        total++; if (ho !== 1'b1 || ro !== 1'b1) begin bad++; $display("FAIL en_hold: got held=%b rel=%b want 1 1", ho, ro); end
        req = 4'hF;
        for (int k = 0; k < 6; k++) begin
            exp = pick(req & cfg_enable, cfg_weight);
            run_pkt(1, 0, 0, 0, gi, g1, gv, ho, ro);
            total++; if (gi == 2 || gi != exp) begin bad++; $display("FAIL en_after pkt%0d: got %0d want %0d", k, gi, exp); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cfg_weight = 16'h1111; cfg_enable = 4'hF; req = 4'b0010; cfg_timeout = 16'd10;
        cyc();
        total++; if (grant_valid !== 1'b1 || grant_idx !== 2'd1) begin bad++; $display("FAIL to_grant: got gv=%b idx=%0d want 1 1", grant_valid, grant_idx); end
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 9) begin
                total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0 at stall 9", err_timeout); end
            end
        end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1 at stall 10", err_timeout); end
        total++; if (err_chan !== 2'd1) begin bad++; $display("FAIL to_chan: got %0d want 1", err_chan); end
        total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL to_keep: got %b want 1", grant_valid); end
        beat_xfer = 1'b1; beat_last = 1'b1;
        cyc();
        beat_xfer = 1'b0; beat_last = 1'b0;
        cyc();
        total++; if (err_timeout !== 1'b1 || err_chan !== 2'd1) begin bad++; $display("FAIL to_sticky: got %b/%0d want 1/1", err_timeout, err_chan); end
        cfg_timeout = '0;
    endtask

    task automatic test_single_ch();
        int exp, gi, cycles; logic [3:0] g1; logic gv, ho, ro;
        do_reset();
        cfg_weight = 16'h2111; cfg_enable = 4'hF; req = 4'b1000;
        cycles = 0;
        for (int k = 0; k < 6; k++) begin
            exp = pick(req & cfg_enable, cfg_weight);
            run_pkt(1, 0, 0, 0, gi, g1, gv, ho, ro);
            cycles += 2;
            total++; if (gi != 3 || gi != exp || gv !== 1'b1) begin bad++; $display("FAIL single pkt%0d: got %0d gv=%b want 3", k, gi, gv); end
            total++; if (g1 !== 4'b1000) begin bad++; $display("FAIL single_1hot pkt%0d: got %b want 1000", k, g1); end
        end
        total++; if (cycles != 12) begin bad++; $display("FAIL single_gaps: got %0d cycles want 12", cycles); end
    endtask

    task automatic test_reset_mid();
        int exp, gi; logic [3:0] g1; logic gv, ho, ro;
        do_reset();
        cfg_weight = 16'h1111; cfg_enable = 4'hF; req = 4'hF; cfg_timeout = 16'd3;
        cyc();
        beat_xfer = 1'b1; beat_last = 1'b0;
        cyc();
        beat_xfer = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        total++; if (err_timeout !== 1'b1 || grant_valid !== 1'b1) begin bad++; $display("FAIL rm_pre: got err=%b gv=%b want 1 1", err_timeout, grant_valid); end
        rst_n = 1'b0;
        cyc();
        total++; if (grant_valid !== 1'b0 || grant_1hot !== 4'b0) begin bad++; $display("FAIL rm_gv: got %b/%b want 0/0000", grant_valid, grant_1hot); end
        total++; if (err_timeout !== 1'b0 || err_chan !== 2'd0) begin bad++; $display("FAIL rm_err: got %b/%0d want 0/0", err_timeout, err_chan); end
        rst_n = 1'b1; cfg_timeout = '0;
        m_ptr = 0; m_quota = 0;
        exp = pick(req & cfg_enable, cfg_weight);
        run_pkt(1, 0, 0, 0, gi, g1, gv, ho, ro);
        total++; if (gi != 1 || gi != exp || gv !== 1'b1) begin bad++; $display("FAIL rm_first: got %0d want 1", gi); end
    endtask

    task automatic test_random();
        int exp, gi; logic [3:0] g1; logic gv, ho, ro;
        do_reset();
        cfg_timeout = '0;
        for (int k = 0; k < 60; k++) begin
            cfg_weight = 16'($urandom);
            if ($urandom_range(3, 0) != 0) cfg_enable = 4'($urandom_range(15, 1));
            if ($urandom_range(2, 0) != 0) req = 4'($urandom);
            if ((req & cfg_enable) == 4'b0) begin
                cyc();
                total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle it%0d: got %b want 0", k, grant_valid); end
                continue;
            end
            exp = pick(req & cfg_enable, cfg_weight);
            run_pkt(int'($urandom_range(4, 1)), 2, 0, 0, gi, g1, gv, ho, ro);
            total++; if (gv !== 1'b1 || gi != exp) begin bad++; $display("FAIL rnd_grant it%0d: got %0d gv=%b want %0d", k, gi, gv, exp); end
            total++; if (g1 !== 4'(1 << exp)) begin bad++; $display("FAIL rnd_1hot it%0d: got %b want %b", k, g1, 4'(1 << exp)); end
            total++; if (ho !== 1'b1 || ro !== 1'b1) begin bad++; $display("FAIL rnd_hold it%0d: got held=%b rel=%b want 1 1", k, ho, ro); end
        end
    endtask

    initial begin
        test_reset();
        test_rr_equal();
        test_weighted();
        test_enable_drop();
        test_timeout();
        test_single_ch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
